ps2_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the same ps2c/ps2d pair the receiver uses.
- Runs the full host-request sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, device ack.
- Top level shares the open-drain lines with the receiver path and uses tx_idle to gate the receiver while transmitting.

---
 rtl/ps2_tx_pkg.sv | 24 ++
 rtl/ps2_clk_filter.sv | 40 ++++
 rtl/ps2_tx.sv | 149 ++++++++++++++
 tb/tb_ps2_tx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_tx_pkg.sv
// Shared PS/2 definitions: transmitter states, protocol bytes and command codes.
// Used by the transmitter top and the reusable clock filter's users.
package ps2_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RTS   = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } ps2_state_t;

  localparam logic [7:0] BRK     = 8'hF0;
  localparam logic [7:0] ACK     = 8'hFA;
  localparam logic [7:0] CMD_LED = 8'hED;
  localparam logic [7:0] CMD_EN  = 8'hF4;
  localparam logic [7:0] CMD_RST = 8'hFF;

  // PS/2 frames use odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock deglitcher: a level is accepted only after FILTER_LEN identical
// samples; fall_edge pulses for one cycle on the accepted 1->0 transition.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  output logic f_ps2c,
  output logic fall_edge
);

  logic [FILTER_LEN-1:0] sr_q;
  logic                  f_q;
  logic                  f_d;

  always_comb begin
    f_d = f_q;
    if (&sr_q)
      f_d = 1'b1;
    else if (~|sr_q)
      f_d = 1'b0;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
      f_q  <= 1'b0;
    end else begin
      sr_q <= {ps2c, sr_q[FILTER_LEN-1:1]};
      f_q  <= f_d;
    end
  end

  assign f_ps2c    = f_q;
  assign fall_edge = f_q & ~f_d;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device command transmitter on shared open-drain ps2c/ps2d lines.
// Optional watchdog between device clock edges enabled by `define PS2_TX_TIMEOUT_EN.
module ps2_tx
  import ps2_tx_pkg::*;
#(
  parameter int RTS_CYCLES     = 5000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2d,
  inout  wire        ps2c,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err
);

  localparam int CNT_MAX = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ps2_state_t       state_q, state_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_err_q, ack_err_d;
  logic             done_q, done_d;
  logic             c_en_q, c_en_d;
  logic             d_en_q, d_en_d;
  logic [1:0]       ps2d_sync_q;
  logic             f_ps2c;
  logic             fall_edge;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .f_ps2c    (f_ps2c),
    .fall_edge (fall_edge)
  );

  // NOTE: every combinational output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_ps2) begin
          shift_d   = {odd_parity(din), din};
          ack_err_d = 1'b0;
          cnt_d     = '0;
          state_d   = RTS;
        end
      end
      RTS: begin
        if (cnt_q == CNT_W'(RTS_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      START: begin
        if (fall_edge) begin
          n_d     = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (fall_edge) begin
          if (n_q == 4'd8) begin
            state_d = STOP;
          end else begin
            shift_d = {1'b0, shift_q[8:1]};
            n_d     = n_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (fall_edge) begin
          ack_err_d = ps2d_sync_q[1];
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog between device edges; a coincident fall_edge takes priority.
    if (state_q == START || state_q == DATA || state_q == STOP) begin
      if (fall_edge) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        cnt_d     = '0;
        ack_err_d = 1'b1;
        done_d    = 1'b1;
        state_d   = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif

    // Line enables are registered from next-state so the pins never glitch.
    c_en_d = (state_d == RTS);
    d_en_d = (state_d == START) || (state_d == DATA && !shift_d[0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      ack_err_q   <= 1'b0;
      done_q      <= 1'b0;
      c_en_q      <= 1'b0;
      d_en_q      <= 1'b0;
      ps2d_sync_q <= 2'b11;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      ack_err_q   <= ack_err_d;
      done_q      <= done_d;
      c_en_q      <= c_en_d;
      d_en_q      <= d_en_d;
      ps2d_sync_q <= {ps2d_sync_q[0], ps2d};
    end
  end

  assign ps2c = c_en_q ? 1'b0 : 1'bz;
  assign ps2d = d_en_q ? 1'b0 : 1'bz;

  assign tx_idle      = (state_q == IDLE);
  assign tx_done_tick = done_q;
  assign ack_err      = ack_err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: a PS/2 device model clocks frames out of the
// DUT and compares every bit and status against a scoreboard queue.
module tb_ps2_tx;
  import ps2_tx_pkg::*;

  localparam int RTS  = 5000;
  localparam int FLEN = 8;
  localparam int TMO  = 3000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  logic       dev_c_low;
  logic       dev_d_low;
  wire        ps2c;
  wire        ps2d;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       ack_err;

  int n_asserts = 0;
  int n_fail    = 0;
  int done_cnt  = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;

  ps2_tx #(
    .RTS_CYCLES     (RTS),
    .FILTER_LEN     (FLEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2d         (ps2d),
    .ps2c         (ps2c),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .ack_err      (ack_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance on falling clock edges, counting done pulses seen along the way.
  task automatic wait_clks(input int n);
    repeat (n) begin
      @(negedge clk);
      if (tx_done_tick) done_cnt++;
    end
  endtask

  // mode 0: normal, 1: second wr_ps2 plus short glitch after edge 4,
  // 2: reset after edge 4, 3: device goes silent after edge 4.
  task automatic transfer(input logic [7:0] d, input bit nack, input int mode);
    int low_cnt;
    int w;
    bit e;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(~^d);
    exp_q.push_back(1'b1);
    exp_q.push_back(nack);
    done_cnt = 0;

    din    = d;
    wr_ps2 = 1'b1;
    wait_clks(1);
    wr_ps2 = 1'b0;
    check("tx_idle_busy", tx_idle, 0);

    low_cnt = 0;
    while (ps2c === 1'b0 && low_cnt < RTS + 100) begin
      low_cnt++;
      wait_clks(1);
    end
    check("rts_len", low_cnt, RTS);

    wait_clks(50);
    e = exp_q.pop_front();
    check("start_bit", ps2d, e);

    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        dev_d_low = !nack;
        wait_clks(5);
      end
      dev_c_low = 1'b1;
      wait_clks(HALF);
      dev_c_low = 1'b0;
      if (k <= 10) begin
        e = exp_q.pop_front();
        check($sformatf("bit_after_edge%0d", k), ps2d, e);
      end
      wait_clks(HALF);

      if (k == 4 && mode == 1) begin
        din    = 8'h00;
        wr_ps2 = 1'b1;
        wait_clks(1);
        wr_ps2 = 1'b0;
        check("wr_ignored_busy", tx_idle, 0);
        dev_c_low = 1'b1;
        wait_clks(3);
        dev_c_low = 1'b0;
        wait_clks(HALF);
      end else if (k == 4 && mode == 2) begin
        reset = 1'b1;
        wait_clks(1);
        check("rst_ps2c_rel", ps2c, 1);
        check("rst_ps2d_rel", ps2d, 1);
        check("rst_tx_idle", tx_idle, 1);
        check("rst_no_done", done_cnt, 0);
        reset = 1'b0;
        wait_clks(30);
        exp_q.delete();
        return;
      end else if (k == 4 && mode == 3) begin
        w = 0;
        while (!tx_idle && w < TMO + 500) begin
          w++;
          wait_clks(1);
        end
        wait_clks(2);
        check("tmo_idle", tx_idle, 1);
        check("tmo_window", (w > TMO - 60 && w < TMO), 1);
        check("tmo_ack_err", ack_err, 1);
        check("tmo_ps2c_rel", ps2c, 1);
        check("tmo_ps2d_rel", ps2d, 1);
        check("tmo_done_cnt", done_cnt, 1);
        exp_q.delete();
        return;
      end
    end

    dev_d_low = 1'b0;
    wait_clks(5);
    e = exp_q.pop_front();
    check("ack_err", ack_err, e);
    check("done_cnt", done_cnt, 1);
    check("tx_idle_end", tx_idle, 1);
    check("ps2c_released", ps2c, 1);
    check("ps2d_released", ps2d, 1);
  endtask

  initial begin
    reset     = 1'b1;
    wr_ps2    = 1'b0;
    din       = 8'h00;
    dev_c_low = 1'b0;
    dev_d_low = 1'b0;
    wait_clks(3);
    check("reset_tx_idle", tx_idle, 1);
    check("reset_done", tx_done_tick, 0);
    check("reset_ack_err", ack_err, 0);
    check("reset_ps2c", ps2c, 1);
    check("reset_ps2d", ps2d, 1);
    reset = 1'b0;
    wait_clks(20);

    transfer(CMD_LED, 1'b0, 0);
    transfer(8'h00, 1'b0, 0);
    transfer(8'h01, 1'b0, 0);
    transfer(CMD_RST, 1'b1, 0);
    transfer(8'hA5, 1'b0, 1);
    transfer(8'h3C, 1'b0, 2);
    transfer(CMD_EN, 1'b0, 0);
`ifdef PS2_TX_TIMEOUT_EN
    transfer(8'h55, 1'b0, 3);
    transfer(CMD_EN, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
